// File: rtl/alu_share_arb_if.sv
// Handshake and ALU-side bundle for alu_share_arb: requesters, shared ALU and tagged response.
// slave = arbiter side, master = requester/ALU/consumer side.
interface alu_share_arb_if #(
   parameter int NREQ = 2,
   parameter int IDW  = 3
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_s;
   logic [32*NREQ-1:0]   req_t;
   logic [10*NREQ-1:0]   req_fs;

   logic [31:0]          alu_s;
   logic [31:0]          alu_t;
   logic [9:0]           alu_fs;
   logic [31:0]          alu_y;
   logic [3:0]           alu_flags;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [31:0]          rsp_y;
   logic [3:0]           rsp_flags;
   logic [IDW-1:0]       rsp_id;
   logic                 rsp_err;
   logic                 busy;

   modport slave (
      input  req_valid, req_s, req_t, req_fs, alu_y, alu_flags, rsp_ready,
      output req_ready, alu_s, alu_t, alu_fs, rsp_valid, rsp_y, rsp_flags,
             rsp_id, rsp_err, busy
   );

   modport master (
      output req_valid, req_s, req_t, req_fs, alu_y, alu_flags, rsp_ready,
      input  req_ready, alu_s, alu_t, alu_fs, rsp_valid, rsp_y, rsp_flags,
             rsp_id, rsp_err, busy
   );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one combinational MIPS_32 ALU between NREQ requesters.
// Optional ALU_FS_CHECK_EN: illegal FS codes bypass the ALU and return rsp_err=1.
module alu_share_arb #(
   parameter int NREQ = 2,
   parameter int IDW  = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   alu_share_arb_if.slave  bus
);

   localparam int NPAD = 1 << IDW;
   localparam int CW   = IDW + 1;
   localparam logic [CW-1:0] NREQ_W = CW'(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_last_grant;
   logic [IDW-1:0]  r_id;
   logic [31:0]     r_alu_s;
   logic [31:0]     r_alu_t;
   logic [9:0]      r_alu_fs;
   logic [31:0]     r_rsp_y;
   logic [3:0]      r_rsp_flags;
`ifdef ALU_FS_CHECK_EN
   logic            r_rsp_err;
`endif

   // Per-requester views padded to 2^IDW entries so an IDW-bit index never overruns.
   logic [NPAD-1:0] w_valid_pad;
   logic [31:0]     w_s  [NPAD];
   logic [31:0]     w_t  [NPAD];
   logic [9:0]      w_fs [NPAD];

   assign w_valid_pad = NPAD'(bus.req_valid);

   for (genvar gi = 0; gi < NPAD; gi++) begin : g_unpack
      if (gi < NREQ) begin : g_real
         assign w_s[gi]  = bus.req_s[32*gi +: 32];
         assign w_t[gi]  = bus.req_t[32*gi +: 32];
         assign w_fs[gi] = bus.req_fs[10*gi +: 10];
      end else begin : g_pad
         assign w_s[gi]  = '0;
         assign w_t[gi]  = '0;
         assign w_fs[gi] = '0;
      end
   end

   // Candidate k is the requester k+1 places after the last grant, wrapped mod NREQ.
   logic [CW-1:0]   w_cand_sum [NREQ];
   logic [IDW-1:0]  w_cand     [NREQ];
   logic [NREQ-1:0] w_cand_vld;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign w_cand_sum[gi] = {1'b0, r_last_grant} + CW'(gi + 1);
      assign w_cand[gi]     = (w_cand_sum[gi] >= NREQ_W) ? IDW'(w_cand_sum[gi] - NREQ_W)
                                                         : w_cand_sum[gi][IDW-1:0];
      assign w_cand_vld[gi] = w_valid_pad[w_cand[gi]];
   end

   logic            w_found;
   logic [IDW-1:0]  w_win;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_cand_vld[k]) begin
            w_found = 1'b1;
            w_win   = w_cand[k];
         end
      end
   end

   logic [NREQ-1:0] w_grant_oh;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_oh
      assign w_grant_oh[gi] = (w_win == IDW'(gi));
   end

   logic w_accept;
   assign w_accept = reset_n && (r_state == IDLE) && w_found;

   function automatic logic cv_defined(input logic [4:0] f);
      case (f)
         5'h02, 5'h03, 5'h04, 5'h05,
         5'h0F, 5'h10, 5'h11, 5'h12: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

   logic w_illegal;
`ifdef ALU_FS_CHECK_EN
   function automatic logic fs_illegal(input logic [4:0] f);
      return (f == 5'h0C) || (f == 5'h0D) || (f == 5'h0E) || (f >= 5'h1A);
   endfunction

   assign w_illegal = fs_illegal(w_fs[w_win][4:0]);
`else
   assign w_illegal = 1'b0;
`endif

   logic w_cv_ok;
   assign w_cv_ok = cv_defined(r_alu_fs[4:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_last_grant <= IDW'(NREQ - 1);
         r_id         <= '0;
         r_alu_s      <= '0;
         r_alu_t      <= '0;
         r_alu_fs     <= '0;
         r_rsp_y      <= '0;
         r_rsp_flags  <= '0;
`ifdef ALU_FS_CHECK_EN
         r_rsp_err    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_id         <= w_win;
                  r_last_grant <= w_win;
                  if (w_illegal) begin
                     // Operand regs stay put so the ALU inputs do not toggle for a rejected op.
                     r_rsp_y     <= '0;
                     r_rsp_flags <= '0;
`ifdef ALU_FS_CHECK_EN
                     r_rsp_err   <= 1'b1;
`endif
                     r_state     <= RESP;
                  end else begin
                     r_alu_s     <= w_s[w_win];
                     r_alu_t     <= w_t[w_win];
                     r_alu_fs    <= w_fs[w_win];
`ifdef ALU_FS_CHECK_EN
                     r_rsp_err   <= 1'b0;
`endif
                     r_state     <= EXEC;
                  end
               end
            end
            EXEC: begin
               r_rsp_y     <= bus.alu_y;
               r_rsp_flags <= {bus.alu_flags[3] & w_cv_ok,
                               bus.alu_flags[2] & w_cv_ok,
                               bus.alu_flags[1:0]};
               r_state     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = w_accept ? w_grant_oh : '0;
   assign bus.alu_s     = r_alu_s;
   assign bus.alu_t     = r_alu_t;
   assign bus.alu_fs    = r_alu_fs;
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_y     = r_rsp_y;
   assign bus.rsp_flags = r_rsp_flags;
   assign bus.rsp_id    = r_id;
   assign bus.busy      = (r_state != IDLE);
`ifdef ALU_FS_CHECK_EN
   assign bus.rsp_err   = r_rsp_err;
`else
   assign bus.rsp_err   = 1'b0;
`endif

endmodule
